// File: rtl/core_tile_scheduler.sv
// Layer-level sequencer for the weight-stationary core: walks an oc_tiles x ic_tiles
// loop nest, launching one core run per tile and tracking the core_busy rise/fall handshake.
module core_tile_scheduler #(
    parameter int ADDR_W  = 11,
    parameter int INST_W  = ADDR_W + 4,
    parameter int TILE_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [TILE_W-1:0] cfg_oc_tiles,
    input  logic [TILE_W-1:0] cfg_ic_tiles,
    input  logic [7:0]        cfg_nij,
    input  logic [7:0]        cfg_kij,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_w_stride,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic [ADDR_W-1:0] cfg_a_stride,
    input  logic [ADDR_W-1:0] cfg_p_base,
    input  logic [ADDR_W-1:0] cfg_p_stride,
    input  logic              abort,
    input  logic              core_busy,
    output logic [INST_W-1:0] core_inst,
    output logic [7:0]        core_nij,
    output logic [7:0]        core_kij,
    output logic [ADDR_W-1:0] core_w_addr,
    output logic [ADDR_W-1:0] core_a_addr,
    output logic [ADDR_W-1:0] core_p_addr,
    output logic              accumulate,
    output logic [TILE_W-1:0] oc_idx,
    output logic [TILE_W-1:0] ic_idx,
    output logic              layer_done,
    output logic              error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_ADVANCE
    } state_t;

    state_t state, state_next;

    logic [TILE_W-1:0] oc_tiles, ic_tiles;
    logic [ADDR_W-1:0] w_stride, a_base, a_stride, p_stride;
    logic [CNT_W-1:0]  cnt;

    logic accept, last_ic, last_oc;
    logic step_ic, step_oc, finish, timeout_hit;

    assign accept    = cfg_valid && (state == S_IDLE);
    assign last_ic   = (ic_idx == ic_tiles - TILE_W'(1));
    assign last_oc   = (oc_idx == oc_tiles - TILE_W'(1));
    assign cfg_ready = (state == S_IDLE);

    always_comb begin
        core_inst             = '0;
        core_inst[ADDR_W + 2] = (state == S_ISSUE);
    end

    assign accumulate = (ic_idx != '0);
    assign layer_done = finish;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        step_ic     = 1'b0;
        step_oc     = 1'b0;
        finish      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE:    if (cfg_valid) state_next = S_ISSUE;
            S_ISSUE:   state_next = S_WAIT_HI;
            S_WAIT_HI: begin
                if (core_busy) begin
                    state_next = S_WAIT_LO;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_next  = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            S_WAIT_LO: if (!core_busy) state_next = S_ADVANCE;
            S_ADVANCE: begin
                state_next = S_ISSUE;
                if (!last_ic) begin
                    step_ic = 1'b1;
                end else if (!last_oc) begin
                    step_oc = 1'b1;
                end else begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default:   state_next = S_IDLE;
        endcase
        // Abort overrides everything, including a final ADVANCE or a timeout.
        if (abort && state != S_IDLE) begin
            state_next  = S_IDLE;
            step_ic     = 1'b0;
            step_oc     = 1'b0;
            finish      = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    // Addresses are running sums: the linear tile index advances by one every tile,
    // so w steps on every advance; a rewinds per oc tile; p steps per oc tile.
    always_ff @(posedge clk) begin
        if (reset) begin
            oc_tiles    <= '0;
            ic_tiles    <= '0;
            w_stride    <= '0;
            a_base      <= '0;
            a_stride    <= '0;
            p_stride    <= '0;
            cnt         <= '0;
            core_nij    <= '0;
            core_kij    <= '0;
            core_w_addr <= '0;
            core_a_addr <= '0;
            core_p_addr <= '0;
            oc_idx      <= '0;
            ic_idx      <= '0;
            error       <= 1'b0;
        end else begin
            if (accept) begin
                oc_tiles    <= (cfg_oc_tiles == '0) ? TILE_W'(1) : cfg_oc_tiles;
                ic_tiles    <= (cfg_ic_tiles == '0) ? TILE_W'(1) : cfg_ic_tiles;
                w_stride    <= cfg_w_stride;
                a_base      <= cfg_a_base;
                a_stride    <= cfg_a_stride;
                p_stride    <= cfg_p_stride;
                core_nij    <= cfg_nij;
                core_kij    <= cfg_kij;
                core_w_addr <= cfg_w_base;
                core_a_addr <= cfg_a_base;
                core_p_addr <= cfg_p_base;
                oc_idx      <= '0;
                ic_idx      <= '0;
                error       <= 1'b0;
            end

            if (state == S_ISSUE)
                cnt <= '0;
            else if (state == S_WAIT_HI && !core_busy)
                cnt <= cnt + CNT_W'(1);

            if (step_ic) begin
                ic_idx      <= ic_idx + TILE_W'(1);
                core_w_addr <= core_w_addr + w_stride;
                core_a_addr <= core_a_addr + a_stride;
            end else if (step_oc) begin
                ic_idx      <= '0;
                oc_idx      <= oc_idx + TILE_W'(1);
                core_w_addr <= core_w_addr + w_stride;
                core_a_addr <= a_base;
                core_p_addr <= core_p_addr + p_stride;
            end

            if (timeout_hit)
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_core_tile_scheduler.sv
// Directed bench for core_tile_scheduler: drives descriptors and a scripted core_busy
// response, checking addresses, flags and handshake timing at each tile.
module tb_core_tile_scheduler;

    localparam int AW = 11;
    localparam int IW = AW + 4;
    localparam int TW = 4;

    logic          clk, reset;
    logic          cfg_valid, cfg_ready;
    logic [TW-1:0] cfg_oc_tiles, cfg_ic_tiles;
    logic [7:0]    cfg_nij, cfg_kij;
    logic [AW-1:0] cfg_w_base, cfg_w_stride, cfg_a_base, cfg_a_stride, cfg_p_base, cfg_p_stride;
    logic          abort, core_busy;
    logic [IW-1:0] core_inst;
    logic [7:0]    core_nij, core_kij;
    logic [AW-1:0] core_w_addr, core_a_addr, core_p_addr;
    logic          accumulate, layer_done, error;
    logic [TW-1:0] oc_idx, ic_idx;

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int dones = 0;
    int s0, d0;

    core_tile_scheduler #(.ADDR_W(AW), .INST_W(IW), .TILE_W(TW), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_oc_tiles(cfg_oc_tiles), .cfg_ic_tiles(cfg_ic_tiles),
        .cfg_nij(cfg_nij), .cfg_kij(cfg_kij),
        .cfg_w_base(cfg_w_base), .cfg_w_stride(cfg_w_stride),
        .cfg_a_base(cfg_a_base), .cfg_a_stride(cfg_a_stride),
        .cfg_p_base(cfg_p_base), .cfg_p_stride(cfg_p_stride),
        .abort(abort), .core_busy(core_busy),
        .core_inst(core_inst), .core_nij(core_nij), .core_kij(core_kij),
        .core_w_addr(core_w_addr), .core_a_addr(core_a_addr), .core_p_addr(core_p_addr),
        .accumulate(accumulate), .oc_idx(oc_idx), .ic_idx(ic_idx),
        .layer_done(layer_done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_inst[AW+2] === 1'b1) starts <= starts + 1;
        if (layer_done === 1'b1)      dones  <= dones + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cfg(input logic [TW-1:0] oc, input logic [TW-1:0] ic,
                            input logic [AW-1:0] wb, input logic [AW-1:0] ws,
                            input logic [AW-1:0] ab, input logic [AW-1:0] ast,
                            input logic [AW-1:0] pb, input logic [AW-1:0] ps,
                            input logic keep);
        cfg_oc_tiles = oc;  cfg_ic_tiles = ic;
        cfg_w_base   = wb;  cfg_w_stride = ws;
        cfg_a_base   = ab;  cfg_a_stride = ast;
        cfg_p_base   = pb;  cfg_p_stride = ps;
        chk("cfg_ready_idle", cfg_ready, 1'b1);
        cfg_valid = 1'b1;
        step();
        if (!keep) cfg_valid = 1'b0;
    endtask

    // Waits for the start pulse, checks the tile, then plays core_busy: rise 2 cycles
    // after the start, held 5 cycles; samples once more to land on ADVANCE.
    task automatic do_tile(input string tag, input int lat,
                           input logic [AW-1:0] w, input logic [AW-1:0] a, input logic [AW-1:0] p,
                           input logic acc, input logic [TW-1:0] oc, input logic [TW-1:0] ic,
                           input logic last);
        int n;
        n = 0;
        while (core_inst[AW+2] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_inst"}, core_inst, 32'h2000);
        chk({tag, "_w"}, core_w_addr, w);
        chk({tag, "_a"}, core_a_addr, a);
        chk({tag, "_p"}, core_p_addr, p);
        chk({tag, "_acc"}, accumulate, acc);
        chk({tag, "_oc"}, oc_idx, oc);
        chk({tag, "_ic"}, ic_idx, ic);
        chk({tag, "_ready"}, cfg_ready, 1'b0);
        step();
        step();
        core_busy = 1'b1;
        repeat (5) step();
        chk({tag, "_acc_hold"}, accumulate, acc);
        chk({tag, "_w_hold"}, core_w_addr, w);
        core_busy = 1'b0;
        step();
        chk({tag, "_done"}, layer_done, last);
    endtask

    initial begin
        reset = 1'b1;
        cfg_valid = 1'b0; abort = 1'b0; core_busy = 1'b0;
        cfg_oc_tiles = '0; cfg_ic_tiles = '0; cfg_nij = 8'h12; cfg_kij = 8'h09;
        cfg_w_base = '0; cfg_w_stride = '0; cfg_a_base = '0; cfg_a_stride = '0;
        cfg_p_base = '0; cfg_p_stride = '0;
        step();
        step();
        chk("rst_ready", cfg_ready, 1'b1);
        chk("rst_inst", core_inst, 0);
        chk("rst_w", core_w_addr, 0);
        chk("rst_nij", core_nij, 0);
        chk("rst_idx", {oc_idx, ic_idx}, 0);
        chk("rst_flags", {accumulate, layer_done, error}, 0);
        reset = 1'b0;
        step();

        // single tile
        send_cfg(4'd1, 4'd1, 11'h010, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 1'b0);
        do_tile("t1", 0, 11'h010, 11'h0, 11'h0, 1'b0, 4'd0, 4'd0, 1'b1);
        chk("t1_starts", starts, 1);
        chk("t1_nij", core_nij, 8'h12);
        chk("t1_kij", core_kij, 8'h09);
        step();
        chk("t1_dones", dones, 1);
        chk("t1_idle", cfg_ready, 1'b1);

        // 2x3 tiling
        send_cfg(4'd2, 4'd3, 11'h000, 11'h008, 11'h100, 11'h020, 11'h400, 11'h040, 1'b0);
        do_tile("g00", 0, 11'h000, 11'h100, 11'h400, 1'b0, 4'd0, 4'd0, 1'b0);
        do_tile("g01", 1, 11'h008, 11'h120, 11'h400, 1'b1, 4'd0, 4'd1, 1'b0);
        do_tile("g02", 1, 11'h010, 11'h140, 11'h400, 1'b1, 4'd0, 4'd2, 1'b0);
        do_tile("g10", 1, 11'h018, 11'h100, 11'h440, 1'b0, 4'd1, 4'd0, 1'b0);
        do_tile("g11", 1, 11'h020, 11'h120, 11'h440, 1'b1, 4'd1, 4'd1, 1'b0);
        do_tile("g12", 1, 11'h028, 11'h140, 11'h440, 1'b1, 4'd1, 4'd2, 1'b1);
        step();
        chk("g_starts", starts, 7);
        chk("g_dones", dones, 2);

        // timeout: core never responds
        s0 = starts; d0 = dones;
        send_cfg(4'd1, 4'd1, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0, 1'b0);
        repeat (15) step();
        chk("to_wait_ready", cfg_ready, 1'b0);
        chk("to_wait_err", error, 1'b0);
        step();
        chk("to_ready", cfg_ready, 1'b1);
        chk("to_err", error, 1'b1);
        repeat (3) step();
        chk("to_err_sticky", error, 1'b1);
        chk("to_no_done", dones, d0);
        chk("to_starts", starts, s0 + 1);

        // abort in WAIT_LO of tile 2; accept also clears error
        send_cfg(4'd1, 4'd3, 11'h000, 11'h004, 11'h000, 11'h010, 11'h080, 11'h000, 1'b0);
        chk("ab_err_clr", error, 1'b0);
        s0 = starts; d0 = dones;
        do_tile("ab0", 0, 11'h000, 11'h000, 11'h080, 1'b0, 4'd0, 4'd0, 1'b0);
        step();
        chk("ab1_start", core_inst[AW+2], 1'b1);
        chk("ab1_w", core_w_addr, 11'h004);
        chk("ab1_a", core_a_addr, 11'h010);
        step();
        step();
        core_busy = 1'b1;
        step();
        step();
        chk("ab1_busy_ready", cfg_ready, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_ready", cfg_ready, 1'b1);
        chk("ab_no_done_now", layer_done, 1'b0);
        repeat (3) step();
        core_busy = 1'b0;
        repeat (5) step();
        chk("ab_starts", starts, s0 + 2);
        chk("ab_dones", dones, d0);
        chk("ab_err", error, 1'b0);

        // wrap and zero oc count; abort with cfg_valid in IDLE still accepts
        abort = 1'b1;
        send_cfg(4'd0, 4'd2, 11'h7F8, 11'h010, 11'h000, 11'h020, 11'h000, 11'h000, 1'b0);
        abort = 1'b0;
        do_tile("wr0", 0, 11'h7F8, 11'h000, 11'h000, 1'b0, 4'd0, 4'd0, 1'b0);
        do_tile("wr1", 1, 11'h008, 11'h020, 11'h000, 1'b1, 4'd0, 4'd1, 1'b1);
        step();

        // cfg_valid held through a layer; next descriptor accepted right after layer_done
        send_cfg(4'd1, 4'd2, 11'h100, 11'h004, 11'h000, 11'h000, 11'h000, 11'h000, 1'b1);
        cfg_w_base = 11'h200; cfg_w_stride = 11'h0; cfg_ic_tiles = 4'd1;
        do_tile("hsA0", 0, 11'h100, 11'h0, 11'h0, 1'b0, 4'd0, 4'd0, 1'b0);
        do_tile("hsA1", 1, 11'h104, 11'h0, 11'h0, 1'b1, 4'd0, 4'd1, 1'b1);
        step();
        chk("hs_idle_ready", cfg_ready, 1'b1);
        step();
        cfg_valid = 1'b0;
        chk("hs_issue", core_inst[AW+2], 1'b1);
        do_tile("hsB", 0, 11'h200, 11'h0, 11'h0, 1'b0, 4'd0, 4'd0, 1'b1);
        step();
        chk("hs_end_ready", cfg_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_tile_scheduler.md
Name: core_tile_scheduler

Overview:
- Layer-level sequencer in front of the weight-stationary core.
- Accepts one layer descriptor, then walks an oc_tiles x ic_tiles loop nest. For each tile it launches one core run (start pulse on the instruction bus plus per-tile SRAM base addresses) and waits for core_busy to complete a rise/fall cycle.
- Adds multi-tile output/input channel support, psum accumulation flagging, a busy-start timeout and abort.

Parameters:
ADDR_W, 11, SRAM address width (matches core)
INST_W, ADDR_W+4, instruction packet width driven to core
TILE_W, 4, width of tile-count fields (max 2^TILE_W-1 tiles per dimension)
TIMEOUT, 15, cycles allowed for core_busy to rise after a start pulse

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  descriptor valid
cfg_ready  out  1  scheduler can accept descriptor
cfg_oc_tiles  in  TILE_W  output-channel tiles (0 treated as 1)
cfg_ic_tiles  in  TILE_W  input-channel tiles (0 treated as 1)
cfg_nij  in  8  nij per run, forwarded unchanged
cfg_kij  in  8  kij per run, forwarded unchanged
cfg_w_base  in  ADDR_W  weight base address
cfg_w_stride  in  ADDR_W  weight address step per (oc,ic) tile
cfg_a_base  in  ADDR_W  activation base address
cfg_a_stride  in  ADDR_W  activation step per ic tile
cfg_p_base  in  ADDR_W  psum base address
cfg_p_stride  in  ADDR_W  psum step per oc tile
abort  in  1  cancel the current layer
core_busy  in  1  busy from core
core_inst  out  INST_W  instruction packet to core
core_nij  out  8  num_nij_to_compute
core_kij  out  8  num_kij_to_compute
core_w_addr  out  ADDR_W  weight_start_sram_addr
core_a_addr  out  ADDR_W  activation_start_sram_addr
core_p_addr  out  ADDR_W  psum base for this tile
accumulate  out  1  high when the current run adds into existing psums (ic_idx != 0)
oc_idx  out  TILE_W  current output tile
ic_idx  out  TILE_W  current input tile
layer_done  out  1  one-cycle pulse, layer finished normally
error  out  1  sticky timeout flag; cleared by the next accepted descriptor or by reset

Behaviour:
- Reset values: state IDLE, cfg_ready=1, core_inst=0, all address/count/index outputs 0, accumulate=0, layer_done=0, error=0.
- Descriptor handshake:
  - Accept on cfg_valid && cfg_ready. Register all cfg fields; zero tile counts are stored as 1.
  - cfg_ready=1 only in IDLE.
- States:
  - IDLE: on accept -> ISSUE; oc_idx=ic_idx=0; error cleared.
  - ISSUE (1 cycle): core_inst[ADDR_W+2]=1; all other inst bits 0 in every state. -> WAIT_HI; timeout counter cleared.
  - WAIT_HI: core_busy=1 -> WAIT_LO. Otherwise counter++; when the counter reaches TIMEOUT -> IDLE with error=1 (no layer_done).
  - WAIT_LO: core_busy=0 -> ADVANCE.
  - ADVANCE (1 cycle):
    - If ic_idx < ic_tiles-1: ic_idx++.
    - Else if oc_idx < oc_tiles-1: ic_idx=0, oc_idx++.
    - Else: layer_done pulses this cycle -> IDLE.
    - Non-final tiles -> ISSUE.
- Address outputs (registered, valid from the ISSUE cycle through the end of that tile):
  - core_w_addr = w_base + (oc_idx*ic_tiles + ic_idx)*w_stride
  - core_a_addr = a_base + ic_idx*a_stride
  - core_p_addr = p_base + oc_idx*p_stride
  - All arithmetic is modulo 2^ADDR_W (wrap silently).
  - Implementation uses incremental running sums, not multipliers.
- accumulate = (ic_idx != 0); it is stable for the whole tile.
- core_nij/core_kij hold the registered cfg values from acceptance until the next acceptance.
- Start-pulse latency: ISSUE occurs exactly 1 cycle after the accept edge, and exactly 1 cycle after ADVANCE for subsequent tiles.
- core_busy already high in ISSUE: ignored; detection starts in WAIT_HI.
- abort:
  - In any non-IDLE state -> IDLE next cycle; no layer_done; error unchanged.
  - If abort arrives in WAIT_LO, the scheduler does not wait for core_busy to fall.
  - abort in IDLE is ignored.
  - abort and cfg_valid together in IDLE: the descriptor is accepted.
- Reset mid-layer: immediate return to reset values; any in-flight core run is not tracked.

Test Plan:
- Single tile: oc=1, ic=1, w_base=0x10. Busy rises 2 cycles after the start pulse and is held 5 cycles -> exactly one start pulse, then layer_done 1 cycle after busy falls, core_w_addr=0x10, accumulate=0.
- 2x3 tiling: oc=2, ic=3, w_base=0, w_stride=8, a_base=0x100, a_stride=0x20, p_base=0x400, p_stride=0x40 -> six starts.
  - core_w_addr sequence 0,8,16,24,32,40.
  - core_a_addr sequence 0x100,0x120,0x140 (repeated per oc tile).
  - core_p_addr 0x400 for the first oc tile, then 0x440.
  - accumulate 0,1,1,0,1,1.
- Timeout: core_busy held 0 after the start pulse -> return to IDLE after TIMEOUT=15 cycles; error=1, no layer_done. The next accepted descriptor clears error.
- Abort: abort asserted in WAIT_LO of tile 2 -> IDLE next cycle, cfg_ready=1, no layer_done, no further start pulse.
- Wrap and zero counts: w_base=0x7F8, w_stride=0x10, oc=0, ic=2 -> treated as oc=1; core_w_addr sequence 0x7F8, 0x008.
- Handshake: cfg_valid held during a layer -> cfg_ready=0 and no acceptance until IDLE; a second descriptor is accepted the cycle after layer_done, and ISSUE follows 1 cycle later.
